// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the serial 1-bit ALU slice controller.
//   ALUOP_*           4-bit {Ainvert, Bnegate, op[1:0]} encodings understood by the slice
//   OP_FIELD_ILLEGAL  op[1:0] value that is rejected without driving the slice
//   OP_FIELD_ADD      op[1:0] value for which carry/overflow flags are meaningful
//   state_t           controller state encoding
package alu_defs;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_NOR = 4'b1100;

  localparam logic [1:0] OP_FIELD_ILLEGAL = 2'b11;
  localparam logic [1:0] OP_FIELD_ADD     = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between the decode stage and the serial ALU controller.
//   req_valid/req_ready  request handshake; req_a, req_b, req_aluop carried with it
//   rsp_valid/rsp_ready  response handshake; rsp_result, rsp_zero, rsp_carry,
//                        rsp_overflow, rsp_err carried with it
// master = request issuer / response consumer, slave = the controller.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_aluop;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_aluop, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_aluop, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err
  );

endinterface

// File: rtl/alu_serial_ctrl.sv
// Serial ALU controller: accepts a WIDTH-bit request and walks an external 1-bit ALU
// slice LSB-first, one bit per cycle, registering the slice carry between bits and
// assembling the result word. Returns result plus zero/carry/overflow/err flags.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   bus (slave)         request/response handshake bundle
//   slice_a, slice_b    operand bits to the slice (0 outside RUN)
//   slice_carryin       carry into the slice (0 outside RUN)
//   slice_aluop         ALUop to the slice (0 outside RUN)
//   slice_result        result bit from the slice
//   slice_carryout      carry out of the slice
module alu_serial_ctrl
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_serial_ctrl_if.slave     bus,
  output logic                 slice_a,
  output logic                 slice_b,
  output logic                 slice_carryin,
  output logic [3:0]           slice_aluop,
  input  logic                 slice_result,
  input  logic                 slice_carryout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               req_ready_q;
  logic               rsp_valid_q;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         aluop_q;
  logic               carry_q;
  logic               cin_msb;

  logic               run;
  logic               last;
  logic               accept;
  logic               is_add;

  assign run    = (state == RUN);
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  // req_ready is high exactly in IDLE, so the handshake reduces to state + valid.
  assign accept = (state == IDLE) && bus.req_valid;
  assign is_add = (aluop_q[1:0] == OP_FIELD_ADD);

  // Control: state, bit counter and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cnt         <= '0;
            req_ready_q <= 1'b0;
            if (bus.req_aluop[1:0] == OP_FIELD_ILLEGAL) begin
              state       <= DONE;
              rsp_valid_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt         <= '0;
            state       <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operands latched on accept, result/carry collected while running.
  // A reset mid-run leaves stale bits here; they are never visible because the
  // outputs are gated by rsp_valid and the next accept clears result_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q      <= bus.req_a;
      b_q      <= bus.req_b;
      aluop_q  <= bus.req_aluop;
      result_q <= '0;
    end else if (run) begin
      result_q[cnt] <= slice_result;
      carry_q       <= slice_carryout;
      if (last) begin
        cin_msb <= slice_carryin;
      end
    end
  end

  // Bit 0 takes Bnegate as carry-in so that SUB forms A + ~B + 1.
  assign slice_a       = run & a_q[cnt];
  assign slice_b       = run & b_q[cnt];
  assign slice_carryin = run & ((cnt == '0) ? aluop_q[2] : carry_q);
  assign slice_aluop   = run ? aluop_q : 4'b0000;

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_valid_q ? result_q : '0;
  assign bus.rsp_zero     = rsp_valid_q & ~|result_q;
  assign bus.rsp_carry    = rsp_valid_q & is_add & carry_q;
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign bus.rsp_overflow = rsp_valid_q & is_add & (cin_msb ^ carry_q);
  assign bus.rsp_err      = rsp_valid_q & (aluop_q[1:0] == OP_FIELD_ILLEGAL);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl with WIDTH=8 and a behavioural 1-bit ALU slice attached.
// Requests push expected responses into a queue; responses pop and compare.
module tb_alu_serial_ctrl;
  import alu_defs::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
    logic         e;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_serial_ctrl_if #(.WIDTH(W)) bus();

  logic       slice_a;
  logic       slice_b;
  logic       slice_carryin;
  logic [3:0] slice_aluop;
  logic       slice_result;
  logic       slice_carryout;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .slice_a        (slice_a),
    .slice_b        (slice_b),
    .slice_carryin  (slice_carryin),
    .slice_aluop    (slice_aluop),
    .slice_result   (slice_result),
    .slice_carryout (slice_carryout)
  );

  // 1-bit ALU slice: optional inversion of each input, then AND/OR/full-add.
  logic sa;
  logic sb;
  always_comb begin
    sa = slice_a ^ slice_aluop[3];
    sb = slice_b ^ slice_aluop[2];
    slice_carryout = (sa & sb) | (sa & slice_carryin) | (sb & slice_carryin);
    case (slice_aluop[1:0])
      2'b00:   slice_result = sa & sb;
      2'b01:   slice_result = sa | sb;
      2'b10:   slice_result = sa ^ sb ^ slice_carryin;
      default: slice_result = 1'b0;
    endcase
  end

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op);
    exp_t         e;
    logic [W-1:0] aa;
    logic [W-1:0] bb;
    logic [W:0]   sum;
    aa    = op[3] ? ~a : a;
    bb    = op[2] ? ~b : b;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.e   = 1'b0;
    e.lat = W + 1;
    case (op[1:0])
      2'b00: e.r = aa & bb;
      2'b01: e.r = aa | bb;
      2'b10: begin
        sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, op[2]};
        e.r = sum[W-1:0];
        e.c = sum[W];
        e.v = (aa[W-1] == bb[W-1]) && (sum[W-1] != aa[W-1]);
      end
      default: begin
        e.r   = '0;
        e.e   = 1'b1;
        e.lat = 1;
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Presents a request for one accept edge; returns at the negedge after acceptance.
  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op, bit push);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_aluop = op;
    chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    if (push) sbq.push_back(model(a, b, op));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_aluop = '0;
  endtask

  // Waits for a response (latency counted in edges from the accept edge), compares it,
  // optionally stalls hold cycles, then completes the handshake.
  task automatic get_rsp(int hold);
    exp_t e;
    int   lat;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e   = sbq.pop_front();
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, e.lat);
    chk("result", {24'b0, bus.rsp_result}, {24'b0, e.r});
    chk("zero", {31'b0, bus.rsp_zero}, {31'b0, e.z});
    chk("carry", {31'b0, bus.rsp_carry}, {31'b0, e.c});
    chk("overflow", {31'b0, bus.rsp_overflow}, {31'b0, e.v});
    chk("err", {31'b0, bus.rsp_err}, {31'b0, e.e});
    chk("req_ready_done", {31'b0, bus.req_ready}, 32'd0);
    if (e.e) chk("slice_aluop_err", {28'b0, slice_aluop}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("hold_result", {24'b0, bus.rsp_result}, {24'b0, e.r});
      chk("hold_flags", {28'b0, bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_err},
          {28'b0, e.z, e.c, e.v, e.e});
      chk("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_cleared", {31'b0, bus.rsp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_aluop = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_slice", {28'b0, slice_aluop}, 32'd0);
    chk("rst_slice_bits", {29'b0, slice_a, slice_b, slice_carryin}, 32'd0);
    chk("rst_rsp_bits", {24'b0, bus.rsp_result}, 32'd0);
    chk("rst_rsp_flags", {28'b0, bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_err}, 32'd0);
    reset = 1'b0;

    send(8'h7F, 8'h01, ALUOP_ADD, 1'b1);
    get_rsp(0);
    send(8'h05, 8'h05, ALUOP_SUB, 1'b1);
    get_rsp(0);
    send(8'hF0, 8'h3C, ALUOP_AND, 1'b1);
    get_rsp(0);
    send(8'hF0, 8'h3C, ALUOP_OR, 1'b1);
    get_rsp(0);
    send(8'hF0, 8'h3C, ALUOP_NOR, 1'b1);
    get_rsp(0);
    send(8'hA5, 8'h5A, 4'b0011, 1'b1);
    get_rsp(0);
    send(8'h10, 8'h30, ALUOP_SUB, 1'b1);
    get_rsp(0);

    // Stalled response with a competing request held valid throughout.
    send(8'h12, 8'h34, ALUOP_ADD, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_a     = 8'h80;
    bus.req_b     = 8'h80;
    bus.req_aluop = ALUOP_ADD;
    get_rsp(5);
    sbq.push_back(model(8'h80, 8'h80, ALUOP_ADD));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_aluop = '0;
    get_rsp(0);

    // Abort mid-run at cnt=3.
    send(8'hAA, 8'h55, ALUOP_ADD, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("abort_slice", {28'b0, slice_aluop}, 32'd0);
    send(8'hFF, 8'h01, ALUOP_ADD, 1'b1);
    get_rsp(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
